key_guard_ctrl: RTL
===================

Name: key_guard_ctrl

Overview:
- Control stage around the 4-bit code comparator.
- Upstream: drives the stored-key input (memyin) of the reference-code register bank through a request/acknowledge enrollment handshake.
- Downstream: consumes the comparator's match output (res) after a fixed pipeline delay and issues grant/deny pulses.
- Counts consecutive mismatches and enforces a timed lockout.

Parameters:
KW, 4, key/code width; must equal comparator width
CHK_LAT, 2, cycles from chk_start to a valid res_in (input register + compare); must be >= 1
MAX_FAIL, 3, consecutive denies that trigger lockout; must be >= 1
LOCK_CYCLES, 16, lockout duration in clock cycles; must be >= 1

Ports:
c  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
enroll_req  input  1  level request to load enroll_code; held until enroll_ack
enroll_code  input  KW  code to store; sampled on the accepting edge
chk_start  input  1  one-cycle pulse; a code is presented to the comparator this cycle
res_in  input  1  comparator match (1 = equal)
memy_out  output  KW  stored key; drives comparator key register input
enroll_ack  output  1  one-cycle pulse; enrollment done
key_valid  output  1  a key has been enrolled since reset
grant  output  1  one-cycle pulse; check matched
deny  output  1  one-cycle pulse; check failed or no key
locked  output  1  high during lockout
fail_cnt  output  clog2(MAX_FAIL+1)  consecutive-fail count

Behaviour:
- Reset (async assert, sync release): state NOKEY. All outputs 0: memy_out, enroll_ack, key_valid, grant, deny, locked, fail_cnt. Internal latency counter and lock timer are cleared.
- Reset mid-operation: the key is lost and any pending check is discarded; no grant/deny is produced.
- States: NOKEY, ENROLL, ARMED, CHECK, LOCKED. All outputs are registered.
- NOKEY:
  - enroll_req=1 -> ENROLL; memy_out <= enroll_code on the same edge.
  - chk_start=1 (without enroll_req) -> deny pulse next cycle; fail_cnt unchanged; stay in NOKEY.
- ENROLL: lasts exactly 1 cycle. enroll_ack=1 and key_valid=1 this cycle -> ARMED.
- Enroll handshake:
  - A new enrollment is accepted only if enroll_req has been seen low since the previous ack (edge-qualified).
  - A request held high after its ack is not re-accepted.
- ARMED:
  - chk_start=1 -> CHECK; latency counter <= CHK_LAT-1.
  - Otherwise, a qualified enroll_req -> ENROLL (re-key); memy_out updated and fail_cnt <= 0.
  - chk_start and enroll_req on the same edge: the check wins. The request stays pending and is accepted on the first ARMED cycle after the check.
- CHECK:
  - The counter decrements each cycle. When it is 0, res_in is sampled that cycle.
  - res_in=1: grant pulse on the next cycle; fail_cnt <= 0; -> ARMED.
  - res_in=0: deny pulse on the next cycle; fail_cnt <= fail_cnt+1. If the new value equals MAX_FAIL -> LOCKED with locked <= 1 and lock timer <= LOCK_CYCLES. Otherwise -> ARMED.
  - chk_start and enroll_req are ignored during CHECK; no queueing.
- Latency: with chk_start high in cycle n, res_in is sampled in cycle n+CHK_LAT and grant/deny is high in cycle n+CHK_LAT+1.
- LOCKED:
  - The lock timer decrements each cycle.
  - On the edge where it reaches 0: locked <= 0, fail_cnt <= 0, -> ARMED. Total locked-high time is exactly LOCK_CYCLES cycles.
  - chk_start produces no grant/deny. enroll_req is not acknowledged and stays pending.
- memy_out changes only on the ENROLL-entry edge. The downstream key register picks it up one edge later, which CHK_LAT already covers.
- grant and deny are never high in the same cycle. fail_cnt saturates at MAX_FAIL and never wraps.

Test Plan:
- Reset with rst_n=0 mid-clock: all outputs 0 immediately, without waiting for an edge. Then chk_start=1 in NOKEY -> deny=1 one cycle later, fail_cnt stays 0.
- Enroll: enroll_req=1, enroll_code=4'h7 -> memy_out=7 and enroll_ack=1 (1 cycle) on the next edge, key_valid=1. Holding enroll_req high afterwards -> no second ack.
- Match: chk_start at cycle 10 with res_in=1 at cycle 12 -> grant=1 at cycle 13 only, deny=0, fail_cnt=0.
- Lockout: three checks with res_in=0 -> deny pulses, fail_cnt 1,2,3. locked=1 for exactly 16 cycles. A chk_start during lockout -> no pulses. After lockout: fail_cnt=0, state ARMED.
- Collision: chk_start and enroll_req (code 4'hA) on the same edge in ARMED -> check completes first with memy_out still 7. enroll_ack follows one cycle after the grant/deny cycle, then memy_out=A.
- Two fails then a match -> fail_cnt back to 0. Two further fails -> no lock, because the count restarted.

Source files
------------

// File: rtl/key_guard_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_guard_ctrl_if
//
// Bundles the handshake and status signals of key_guard_ctrl so the
// controller and its environment connect through one port.
//
//   enroll_req   master->slave  level request to load enroll_code
//   enroll_code  master->slave  code to store (KW bits)
//   chk_start    master->slave  one-cycle pulse: a code enters the comparator
//   res_in       master->slave  comparator match result (1 = equal)
//   memy_out     slave->master  stored key, feeds the comparator key register
//   enroll_ack   slave->master  one-cycle pulse: enrollment done
//   key_valid    slave->master  a key has been enrolled since reset
//   grant        slave->master  one-cycle pulse: check matched
//   deny         slave->master  one-cycle pulse: check failed or no key
//   locked       slave->master  high during lockout
//   fail_cnt     slave->master  consecutive-fail count
//
// The master modport is the environment (stimulus side); the slave modport
// is the controller.
// ---------------------------------------------------------------------------
interface key_guard_ctrl_if #(
    parameter int KW       = 4,
    parameter int MAX_FAIL = 3
);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic          enroll_req;
    logic [KW-1:0] enroll_code;
    logic          chk_start;
    logic          res_in;
    logic [KW-1:0] memy_out;
    logic          enroll_ack;
    logic          key_valid;
    logic          grant;
    logic          deny;
    logic          locked;
    logic [FW-1:0] fail_cnt;

    modport master (
        output enroll_req,
        output enroll_code,
        output chk_start,
        output res_in,
        input  memy_out,
        input  enroll_ack,
        input  key_valid,
        input  grant,
        input  deny,
        input  locked,
        input  fail_cnt
    );

    modport slave (
        input  enroll_req,
        input  enroll_code,
        input  chk_start,
        input  res_in,
        output memy_out,
        output enroll_ack,
        output key_valid,
        output grant,
        output deny,
        output locked,
        output fail_cnt
    );
endinterface

// File: rtl/key_guard_ctrl.sv
// ---------------------------------------------------------------------------
// key_guard_ctrl
//
// Control stage wrapped around a KW-bit code comparator.
//   * Enrollment: a request/acknowledge handshake loads the stored key
//     (memy_out) that drives the comparator's key register.
//   * Checking: a chk_start pulse launches a compare; the comparator's match
//     output res_in is sampled CHK_LAT cycles later and turned into a single
//     grant or deny pulse on the following cycle.
//   * Lockout: MAX_FAIL consecutive denies hold the block locked for
//     LOCK_CYCLES cycles, during which checks and enrollments are refused.
//
// Ports
//   c      : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset; release is expected to be
//            synchronised to c upstream
//   bus    : key_guard_ctrl_if.slave (enroll_req, enroll_code, chk_start,
//            res_in in; memy_out, enroll_ack, key_valid, grant, deny,
//            locked, fail_cnt out). All outputs are registered.
//
// Parameters
//   KW          : key/code width, equal to the comparator width
//   CHK_LAT     : cycles from chk_start to a valid res_in (>= 1)
//   MAX_FAIL    : consecutive denies that trigger lockout (>= 1)
//   LOCK_CYCLES : lockout duration in cycles (>= 1)
// ---------------------------------------------------------------------------
module key_guard_ctrl #(
    parameter int KW          = 4,
    parameter int CHK_LAT     = 2,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic            c,
    input  logic            rst_n,
    key_guard_ctrl_if.slave bus
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    localparam logic [2:0] st_nokey  = 3'd0;
    localparam logic [2:0] st_enroll = 3'd1;
    localparam logic [2:0] st_armed  = 3'd2;
    localparam logic [2:0] st_check  = 3'd3;
    localparam logic [2:0] st_locked = 3'd4;

    logic [2:0]    state_reg,  state_next;
    logic [KW-1:0] memy_reg,   memy_next;
    logic          ack_reg,    ack_next;
    logic          valid_reg,  valid_next;
    logic          grant_reg,  grant_next;
    logic          deny_reg,   deny_next;
    logic          locked_reg, locked_next;
    logic [FW-1:0] fail_reg,   fail_next;
    logic [CW-1:0] lat_reg,    lat_next;
    logic [TW-1:0] timer_reg,  timer_next;
    // Set once enroll_req has been observed low since the last accepted
    // enrollment; a request still held high after its ack is not re-taken.
    logic          req_ok_reg, req_ok_next;

    logic          enroll_go;

    assign enroll_go = bus.enroll_req & req_ok_reg;

    always_comb begin
        state_next  = state_reg;
        memy_next   = memy_reg;
        ack_next    = 1'b0;
        valid_next  = valid_reg;
        grant_next  = 1'b0;
        deny_next   = 1'b0;
        locked_next = locked_reg;
        fail_next   = fail_reg;
        lat_next    = lat_reg;
        timer_next  = timer_reg;
        req_ok_next = req_ok_reg | ~bus.enroll_req;

        case (state_reg)
            st_nokey: begin
                if (enroll_go) begin
                    state_next  = st_enroll;
                    memy_next   = bus.enroll_code;
                    ack_next    = 1'b1;
                    valid_next  = 1'b1;
                    req_ok_next = 1'b0;
                end else if (bus.chk_start) begin
                    // No key to compare against: refuse without counting.
                    deny_next = 1'b1;
                end
            end

            st_enroll: begin
                // Single-cycle state; ack and key_valid were raised on entry.
                state_next = st_armed;
            end

            st_armed: begin
                // A check takes priority over a simultaneous re-key; the
                // request stays qualified and is taken after the check.
                if (bus.chk_start) begin
                    state_next = st_check;
                    lat_next   = CW'(CHK_LAT - 1);
                end else if (enroll_go) begin
                    state_next  = st_enroll;
                    memy_next   = bus.enroll_code;
                    ack_next    = 1'b1;
                    valid_next  = 1'b1;
                    fail_next   = '0;
                    req_ok_next = 1'b0;
                end
            end

            st_check: begin
                if (lat_reg == '0) begin
                    if (bus.res_in) begin
                        grant_next = 1'b1;
                        fail_next  = '0;
                        state_next = st_armed;
                    end else begin
                        deny_next = 1'b1;
                        if (fail_reg >= FW'(MAX_FAIL - 1)) begin
                            // This deny completes the run: saturate and lock.
                            fail_next   = FW'(MAX_FAIL);
                            locked_next = 1'b1;
                            timer_next  = TW'(LOCK_CYCLES);
                            state_next  = st_locked;
                        end else begin
                            fail_next  = fail_reg + FW'(1);
                            state_next = st_armed;
                        end
                    end
                end else begin
                    lat_next = lat_reg - CW'(1);
                end
            end

            st_locked: begin
                // The timer is loaded with LOCK_CYCLES on entry, so leaving
                // on the edge where it would hit zero gives exactly
                // LOCK_CYCLES cycles of locked high.
                if (timer_reg <= TW'(1)) begin
                    timer_next  = '0;
                    locked_next = 1'b0;
                    fail_next   = '0;
                    state_next  = st_armed;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            default: begin
                state_next = st_nokey;
            end
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= st_nokey;
            memy_reg   <= '0;
            ack_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            grant_reg  <= 1'b0;
            deny_reg   <= 1'b0;
            locked_reg <= 1'b0;
            fail_reg   <= '0;
            lat_reg    <= '0;
            timer_reg  <= '0;
            // No ack has happened yet, so the first request qualifies.
            req_ok_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            memy_reg   <= memy_next;
            ack_reg    <= ack_next;
            valid_reg  <= valid_next;
            grant_reg  <= grant_next;
            deny_reg   <= deny_next;
            locked_reg <= locked_next;
            fail_reg   <= fail_next;
            lat_reg    <= lat_next;
            timer_reg  <= timer_next;
            req_ok_reg <= req_ok_next;
        end
    end

    assign bus.memy_out   = memy_reg;
    assign bus.enroll_ack = ack_reg;
    assign bus.key_valid  = valid_reg;
    assign bus.grant      = grant_reg;
    assign bus.deny       = deny_reg;
    assign bus.locked     = locked_reg;
    assign bus.fail_cnt   = fail_reg;

endmodule
